// File: rtl/seven_segment_reader.sv
// rtl/seven_segment_reader.sv - seven-segment digit stream monitor: filter, decode, sequence and period check
module seven_segment_reader #(
  parameter int STABLE_CYCLES = 4,
  parameter int PERIOD_W      = 21
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [6:0]          segments,
  input  logic                clear_errors,
  output logic [3:0]          digit,
  output logic                digit_valid,
  output logic                step,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic [7:0]          step_count,
  output logic                seq_error,
  output logic                pattern_error
);

  typedef enum logic [0:0] {WAIT_FIRST, TRACK} state_t;

  // stab counts repeats of cand after the first sample, so it saturates at STABLE_CYCLES-1;
  // acceptance is taken on the cycle whose matching sample brings it there.
  localparam logic [3:0]          STAB_MAX = 4'(STABLE_CYCLES - 1);
  localparam logic [3:0]          STAB_PRE = 4'(STABLE_CYCLES - 2);
  localparam logic [PERIOD_W-1:0] P_ONE    = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] P_MAX    = '1;

  state_t              state;
  logic [6:0]          seg_m;
  logic [6:0]          seg_s;
  logic [6:0]          cand;
  logic [6:0]          last_pat;
  logic [3:0]          stab;
  logic [PERIOD_W-1:0] pcnt;
  logic [PERIOD_W-1:0] cap;
  logic                accept;
  logic                dec_valid;
  logic [3:0]          dec_digit;
  logic [3:0]          next_digit;

  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h3F:   r = {1'b1, 4'd0};
      7'h06:   r = {1'b1, 4'd1};
      7'h5B:   r = {1'b1, 4'd2};
      7'h4F:   r = {1'b1, 4'd3};
      7'h66:   r = {1'b1, 4'd4};
      7'h6D:   r = {1'b1, 4'd5};
      7'h7C:   r = {1'b1, 4'd6};
      7'h07:   r = {1'b1, 4'd7};
      7'h7F:   r = {1'b1, 4'd8};
      7'h67:   r = {1'b1, 4'd9};
      default: r = {1'b0, 4'd0};
    endcase
    return r;
  endfunction

  // Acceptance strobe, decoded candidate, saturating period capture and expected successor.
  always_comb begin
    accept                 = (seg_s == cand) && (stab == STAB_PRE) && (cand != last_pat);
    {dec_valid, dec_digit} = decode(cand);
    cap                    = (pcnt == P_MAX) ? pcnt : pcnt + P_ONE;
    next_digit             = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
  end

  // Two-flop synchronizer for the asynchronous segment bus.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seg_m <= '0;
      seg_s <= '0;
    end else begin
      seg_m <= segments;
      seg_s <= seg_m;
    end
  end

  // Stability filter; last_pat blocks re-acceptance of a pattern returning after a glitch.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cand     <= '0;
      stab     <= '0;
      last_pat <= '0;
    end else begin
      if (seg_s != cand) begin
        cand <= seg_s;
        stab <= '0;
      end else if (stab != STAB_MAX) begin
        stab <= stab + 4'd1;
      end
      if (accept) last_pat <= cand;
    end
  end

  // Free-running saturating cycle counter, restarted at every acceptance.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pcnt <= '0;
    end else if (accept) begin
      pcnt <= '0;
    end else if (pcnt != P_MAX) begin
      pcnt <= pcnt + P_ONE;
    end
  end

  // Sequence tracker with registered outputs; a new error wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= WAIT_FIRST;
      digit         <= '0;
      digit_valid   <= 1'b0;
      step          <= 1'b0;
      period        <= '0;
      period_valid  <= 1'b0;
      step_count    <= '0;
      seq_error     <= 1'b0;
      pattern_error <= 1'b0;
    end else begin
      step <= 1'b0;
      if (clear_errors) begin
        seq_error     <= 1'b0;
        pattern_error <= 1'b0;
      end
      if (accept) begin
        case (state)
          WAIT_FIRST: begin
            if (dec_valid) begin
              digit       <= dec_digit;
              digit_valid <= 1'b1;
              state       <= TRACK;
            end else begin
              pattern_error <= 1'b1;
            end
          end
          TRACK: begin
            if (dec_valid) begin
              if (dec_digit == next_digit) begin
                step         <= 1'b1;
                period       <= cap;
                period_valid <= 1'b1;
                step_count   <= step_count + 8'd1;
              end else begin
                seq_error <= 1'b1;
              end
              digit <= dec_digit;
            end else begin
              pattern_error <= 1'b1;
              digit_valid   <= 1'b0;
              state         <= WAIT_FIRST;
            end
          end
          default: state <= WAIT_FIRST;
        endcase
      end
    end
  end

endmodule

// File: doc/seven_segment_reader.md
# seven_segment_reader

Receive-side monitor for the seven-segment digit stream produced by our seconds counter. It samples the 7-bit segment bus and filters out glitches. It decodes each stable pattern back to a BCD digit, checks that digits advance 0→1→…→9→0, and measures the clock-cycle period between steps. It sits on the input pins of a checker tile, or in the bench as a self-checking observer of the display output.

## Interface
Parameters:
- `STABLE_CYCLES`, default 4: consecutive synchronized samples a pattern must hold before it is accepted. Legal range is 2..15.
- `PERIOD_W`, default 21: width of the period counter and the `period` output.

Ports:
- `clk`, input, 1: single clock. All logic is rising-edge.
- `reset_n`, input, 1: synchronous, active-low reset.
- `segments`, input, 7: segment bus `{g,f,e,d,c,b,a}`, active high. It is asynchronous to `clk`.
- `clear_errors`, input, 1: one-cycle strobe that clears the sticky error flags.
- `digit`, output, 4: last accepted valid digit.
- `digit_valid`, output, 1: `digit` holds a decoded value.
- `step`, output, 1: one-cycle pulse on a legal successor digit.
- `period`, output, PERIOD_W: cycles between the last two accepted changes, captured on `step` only.
- `period_valid`, output, 1: `period` has been captured at least once since reset.
- `step_count`, output, 8: number of legal steps, wraps at 255→0.
- `seq_error`, output, 1: sticky flag; a valid digit arrived that was not the successor.
- `pattern_error`, output, 1: sticky flag; a stable pattern was accepted that is not in the code table.

## Operation
- **Code table (hex):** 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7C, 7=07, 8=7F, 9=67. Every other value, including 00, is invalid.
- **Synchronizer:** two flops on `segments`; the second-stage output is `seg_s`.
- **Stability filter:**
  - A register `cand` holds the most recent `seg_s` value, with a counter `stab`.
  - If `seg_s` ≠ `cand`, load `cand` and set `stab`=0. Otherwise increment `stab`, saturating at STABLE_CYCLES-1.
  - Acceptance fires for one cycle when `stab` reaches STABLE_CYCLES-1 and `cand` ≠ `last_pat`. On acceptance, `last_pat` ← `cand`.
- **Period counter `pcnt`:** increments every cycle, saturating at all-ones. On acceptance, `cap` = `pcnt`+1 (saturating) and `pcnt` ← 0.
- **FSM states:**
  - WAIT_FIRST (the reset state):
    - Accept of a valid digit: `digit` ← decoded value, `digit_valid` ← 1, go to TRACK. No `step`.
    - Accept of an invalid pattern: set `pattern_error`, stay in WAIT_FIRST.
  - TRACK:
    - Valid digit equal to (`digit`+1) mod 10: pulse `step`, `period` ← `cap`, `period_valid` ← 1, `step_count` += 1, update `digit`.
    - Any other valid digit: set `seq_error`, update `digit`, stay in TRACK (resync). `period` is unchanged.
    - Invalid pattern: set `pattern_error`, `digit_valid` ← 0, go to WAIT_FIRST.
- **Modulo wrap:** 9→0 is a legal step.
- **Re-accept rule:** the same pattern returning after a glitch shorter than STABLE_CYCLES is never re-accepted.
- **Error-clear priority:** `clear_errors` in the same cycle as a new error leaves that flag set; the set wins.
- **Reset values (mid-operation reset as well):**
  - `digit`=0, `digit_valid`=0, `step`=0, `period`=0, `period_valid`=0, `step_count`=0, `seq_error`=0, `pattern_error`=0.
  - `pcnt`=0, `stab`=0, `cand`=00, `last_pat`=00, synchronizer flops cleared, FSM in WAIT_FIRST.
  - Because `last_pat` resets to 00, a held 00 after reset is never accepted.

## Timing
- Let the first clock edge that samples a new pattern on `segments` be edge E, with the pattern held stable afterwards.
  - The pattern appears on `seg_s` after edge E+1.
  - Acceptance fires in the cycle after edge E+1+STABLE_CYCLES-1.
  - Outputs (`digit`, `step`, `period`, flags) update at edge E+1+STABLE_CYCLES.
- Total latency is STABLE_CYCLES+1 edges after E, which is 5 with the default.
- `step` is high for exactly one cycle per legal step. Back-to-back steps are impossible: at least STABLE_CYCLES cycles separate acceptances.
- Period accuracy:
  - For a source that changes every M cycles (M ≥ STABLE_CYCLES+1), `period` = M exactly.
  - If more than 2^PERIOD_W-1 cycles elapse, `period` reads all-ones.
- Outputs are registered; no combinational path runs from `segments` or `clear_errors` to any output.

## Test plan
- **Reset and clean count:** `reset_n`=0 for 3 cycles, then `segments` steps 3F,06,5B… every 100 cycles through 9→0 and on to 2.
  - Expect `step` pulses = 12 and `step_count`=12.
  - Expect `period`=100 and `period_valid`=1.
  - No error flags.
- **Glitch rejection:** `segments` at 4F (digit 3), then a 2-cycle pulse of 7F, then back to 4F.
  - No `step`, `digit` stays 3, no errors, `period` unchanged.
- **Skip:** after digit 2 (5B), drive 66 (digit 4).
  - `seq_error`=1, `digit`=4, `step`=0.
  - The next 6D (digit 5) gives `step`=1, with `period` measured from the 66 acceptance.
- **Invalid pattern:** during TRACK, hold 00 for 10 cycles.
  - `pattern_error`=1 and `digit_valid`=0.
  - The following 06 gives `digit`=1 and `digit_valid`=1 with no `step`.
- **Clear priority:** pulse `clear_errors` in the same cycle a skip is accepted, and `seq_error` stays 1.
  - Pulse `clear_errors` alone, and both flags read 0 on the next cycle.
- **Reset mid-operation:** set `reset_n`=0 at `step_count`=7 with `period`=100.
  - All outputs read their reset values on the next edge.
  - After release, the current stable 6D is accepted as the first digit 5, with no `step`.
